// File: rtl/cva6_lsu_mem_resp_if.sv
// LSU <-> memory-response handshake: level load request, store-commit pulses and response pulses.
// The responder (cva6_lsu_mem_resp) takes the slave side and the LSU takes the master side.
interface cva6_lsu_mem_resp_if;
    logic load_req_i;
    logic store_commit_i;
    logic load_mem_resp_o;
    logic store_mem_resp_o;

    modport slave (
        input  load_req_i,
        input  store_commit_i,
        output load_mem_resp_o,
        output store_mem_resp_o
    );

    modport master (
        output load_req_i,
        output store_commit_i,
        input  load_mem_resp_o,
        input  store_mem_resp_o
    );
endinterface

// File: rtl/cva6_lsu_mem_resp.sv
// Fixed-latency load/store response generator for the CVA6 LSU; loads take priority over queued stores.
// Define CVA6_LSU_MEM_RESP_STALL_EN to add stall_i, which freezes the FSM and latency counter.
module cva6_lsu_mem_resp #(
    parameter int unsigned LOAD_LAT  = 2,
    parameter int unsigned STORE_LAT = 3,
    parameter int unsigned ST_DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    cva6_lsu_mem_resp_if.slave        bus,
    output logic                      busy_o,
    output logic [2:0]                pending_stores_o,
    output logic                      overflow_o
`ifdef CVA6_LSU_MEM_RESP_STALL_EN
    ,
    input  logic                      stall_i
`endif
);

    typedef enum logic [1:0] {IDLE, LD_BUSY, ST_BUSY, LD_WAIT} state_e;

    localparam logic [3:0] LD_CNT = 4'(LOAD_LAT - 1);
    localparam logic [3:0] ST_CNT = 4'(STORE_LAT - 1);
    localparam logic [2:0] DEPTH  = 3'(ST_DEPTH);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ld_resp_q, ld_resp_d;
    logic       st_resp_q, st_resp_d;
    logic       busy_q, busy_d;
    logic [2:0] pend_q, pend_d;
    logic       ovf_q, ovf_d;
    logic       stall;

`ifdef CVA6_LSU_MEM_RESP_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A commit in the same cycle as an idle FSM is accepted immediately.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (bus.load_req_i) begin
                        state_d = LD_BUSY;
                        cnt_d   = LD_CNT;
                    end else if (pend_q != 3'd0 || bus.store_commit_i) begin
                        state_d = ST_BUSY;
                        cnt_d   = ST_CNT;
                    end
                end
                LD_BUSY: begin
                    if (cnt_q == 4'd0) state_d = LD_WAIT;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                LD_WAIT: begin
                    if (!bus.load_req_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ld_resp_d = !stall && state_q == LD_BUSY && cnt_q == 4'd0;
        st_resp_d = !stall && state_q == ST_BUSY && cnt_q == 4'd0;
        busy_d    = state_d != IDLE;
        pend_d    = pend_q;
        ovf_d     = ovf_q;
        case ({bus.store_commit_i, st_resp_d})
            2'b10: begin
                if (pend_q == DEPTH) ovf_d  = 1'b1;
                else                 pend_d = pend_q + 3'd1;
            end
            2'b01:   pend_d = pend_q - 3'd1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_resp_q <= 1'b0;
            st_resp_q <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            ld_resp_q <= ld_resp_d;
            st_resp_q <= st_resp_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.load_mem_resp_o  = ld_resp_q;
    assign bus.store_mem_resp_o = st_resp_q;
    assign busy_o               = busy_q;
    assign pending_stores_o     = pend_q;
    assign overflow_o           = ovf_q;

endmodule

// File: tb/tb_cva6_lsu_mem_resp.sv
// Directed bench for cva6_lsu_mem_resp with default latencies (LOAD_LAT=2, STORE_LAT=3, ST_DEPTH=4).
module tb_cva6_lsu_mem_resp;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       busy_o;
    logic [2:0] pending_stores_o;
    logic       overflow_o;
    int         n_chk = 0;
    int         n_err = 0;
`ifdef CVA6_LSU_MEM_RESP_STALL_EN
    logic       stall_i = 1'b0;
`endif

    cva6_lsu_mem_resp_if bus ();

    cva6_lsu_mem_resp dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .bus              (bus.slave),
        .busy_o           (busy_o),
        .pending_stores_o (pending_stores_o),
        .overflow_o       (overflow_o)
`ifdef CVA6_LSU_MEM_RESP_STALL_EN
        ,
        .stall_i          (stall_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then check all outputs just after it.
    task automatic step_chk(input string tag, input logic ld, input logic st,
                            input logic bz, input logic [2:0] pd);
        @(posedge clk_i); #1;
        check({tag, "/ld"},   32'(bus.load_mem_resp_o),  32'(ld));
        check({tag, "/st"},   32'(bus.store_mem_resp_o), 32'(st));
        check({tag, "/busy"}, 32'(busy_o),               32'(bz));
        check({tag, "/pend"}, 32'(pending_stores_o),     32'(pd));
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    initial begin
        int st_cnt;
        bus.load_req_i     = 1'b0;
        bus.store_commit_i = 1'b0;
        tick(2);
        check("rst/ld",   32'(bus.load_mem_resp_o),  0);
        check("rst/st",   32'(bus.store_mem_resp_o), 0);
        check("rst/busy", 32'(busy_o),               0);
        check("rst/pend", 32'(pending_stores_o),     0);
        check("rst/ovf",  32'(overflow_o),           0);
        rst_ni = 1'b1;

        // Load accepted on first edge after reset release; response 2 edges later.
        bus.load_req_i = 1'b1;
        step_chk("ld1", 0, 0, 1, 0);
        step_chk("ld2", 0, 0, 1, 0);
        step_chk("ld3", 1, 0, 1, 0);
        bus.load_req_i = 1'b0;
        step_chk("ld4", 0, 0, 0, 0);

        // Two back-to-back commits: responses 3 and 7 edges after the first commit.
        bus.store_commit_i = 1'b1;
        step_chk("st1", 0, 0, 1, 1);
        step_chk("st2", 0, 0, 1, 2);
        bus.store_commit_i = 1'b0;
        step_chk("st3", 0, 0, 1, 2);
        step_chk("st4", 0, 1, 0, 1);
        step_chk("st5", 0, 0, 1, 1);
        step_chk("st6", 0, 0, 1, 1);
        step_chk("st7", 0, 0, 1, 1);
        step_chk("st8", 0, 1, 0, 0);
        step_chk("st9", 0, 0, 0, 0);

        // Simultaneous load and commit: load wins, store served after LD_WAIT exits.
        bus.load_req_i     = 1'b1;
        bus.store_commit_i = 1'b1;
        step_chk("mx1", 0, 0, 1, 1);
        bus.store_commit_i = 1'b0;
        step_chk("mx2", 0, 0, 1, 1);
        step_chk("mx3", 1, 0, 1, 1);
        bus.load_req_i = 1'b0;
        step_chk("mx4", 0, 0, 0, 1);
        step_chk("mx5", 0, 0, 1, 1);
        step_chk("mx6", 0, 0, 1, 1);
        step_chk("mx7", 0, 0, 1, 1);
        step_chk("mx8", 0, 1, 0, 0);

        // Load request dropped during LD_BUSY still gets its response.
        bus.load_req_i = 1'b1;
        step_chk("ab1", 0, 0, 1, 0);
        bus.load_req_i = 1'b0;
        step_chk("ab2", 0, 0, 1, 0);
        step_chk("ab3", 1, 0, 1, 0);
        step_chk("ab4", 0, 0, 0, 0);

`ifdef CVA6_LSU_MEM_RESP_STALL_EN
        // Two stall cycles inside LD_BUSY push the response out by two edges.
        bus.load_req_i = 1'b1;
        step_chk("sl1", 0, 0, 1, 0);
        stall_i = 1'b1;
        step_chk("sl2", 0, 0, 1, 0);
        step_chk("sl3", 0, 0, 1, 0);
        stall_i = 1'b0;
        step_chk("sl4", 0, 0, 1, 0);
        step_chk("sl5", 1, 0, 1, 0);
        bus.load_req_i = 1'b0;
        step_chk("sl6", 0, 0, 0, 0);
`endif

        // Five commits while a held load blocks store service: saturate at 4, overflow sticks.
        bus.load_req_i     = 1'b1;
        bus.store_commit_i = 1'b1;
        step_chk("of1", 0, 0, 1, 1);
        step_chk("of2", 0, 0, 1, 2);
        step_chk("of3", 1, 0, 1, 3);
        step_chk("of4", 0, 0, 1, 4);
        check("of4/ovf", 32'(overflow_o), 0);
        step_chk("of5", 0, 0, 1, 4);
        check("of5/ovf", 32'(overflow_o), 1);
        bus.store_commit_i = 1'b0;
        step_chk("of6", 0, 0, 1, 4);
        bus.load_req_i = 1'b0;
        st_cnt = 0;
        repeat (20) begin
            tick(1);
            if (bus.store_mem_resp_o === 1'b1) st_cnt++;
        end
        check("drain/resps", 32'(st_cnt),           4);
        check("drain/pend",  32'(pending_stores_o), 0);
        check("drain/ovf",   32'(overflow_o),       1);
        check("drain/busy",  32'(busy_o),           0);

        // Asynchronous reset in the first ST_BUSY cycle discards the in-flight store.
        bus.store_commit_i = 1'b1;
        step_chk("rs1", 0, 0, 1, 1);
        bus.store_commit_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("rs/busy", 32'(busy_o),               0);
        check("rs/pend", 32'(pending_stores_o),     0);
        check("rs/ovf",  32'(overflow_o),           0);
        check("rs/st",   32'(bus.store_mem_resp_o), 0);
        tick(2);
        rst_ni = 1'b1;
        st_cnt = 0;
        repeat (6) begin
            tick(1);
            if (bus.store_mem_resp_o === 1'b1) st_cnt++;
        end
        check("rs/after_resps", 32'(st_cnt), 0);
        check("rs/after_busy",  32'(busy_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
